// File: rtl/alu_pkg.sv
// Shared types for the relay ALU stage: function codes, sequencer states, condition flags.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int ALU_MAX_SETTLE = 15;

  typedef enum logic [2:0] {
    FN_ADD = 3'b000,
    FN_INC = 3'b001,
    FN_AND = 3'b010,
    FN_OR  = 3'b011,
    FN_XOR = 3'b100,
    FN_NOT = 3'b101,
    FN_SHL = 3'b110,
    FN_CLR = 3'b111
  } alu_fn_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOAD   = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic s;
    logic c;
    logic z;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational relay-ALU function block: result plus next condition flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; carry_in is passed through for functions that leave carry alone.
module alu_core
  import alu_pkg::*;
(
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic [2:0] fn,
  input  logic       carry_in,
  output logic [7:0] result,
  output alu_flags_t flags
);

  logic [8:0] sum9;
  logic       carry_out;

  // Evaluate the selected function; only ADD/INC produce a new carry.
  always_comb begin
    sum9      = 9'd0;
    result    = 8'h00;
    carry_out = carry_in;
    case (fn)
      FN_ADD: begin
        sum9      = {1'b0, b} + {1'b0, c};
        result    = sum9[7:0];
        carry_out = sum9[8];
      end
      FN_INC: begin
        sum9      = {1'b0, b} + 9'd1;
        result    = sum9[7:0];
        carry_out = sum9[8];
      end
      FN_AND:  result = b & c;
      FN_OR:   result = b | c;
      FN_XOR:  result = b ^ c;
      FN_NOT:  result = ~b;
      FN_SHL:  result = {b[6:0], b[7]};
      default: result = 8'h00;
    endcase
    flags.s = result[7];
    flags.c = carry_out;
    flags.z = (result == 8'h00);
  end

endmodule

// File: rtl/alu_sequencer.sv
// Relay-timed ALU stage: latch B/C/fn on start, wait SETTLE_CYCLES, register result+flags, pulse ld_a/ld_d.
// Latency: result/done/ld_* valid SETTLE_CYCLES+1 cycles after the start edge; one op per SETTLE_CYCLES+2 cycles.
// Backpressure: start is ignored while busy (no queueing). Optional lamps via ALU_LED_EN (led_fn, led_busy).
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int N             = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  input  logic [2:0]   fn,
  input  logic         dest_d,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         ld_a,
  output logic         ld_d,
  output logic         flag_s,
  output logic         flag_c,
  output logic         flag_z
`ifdef ALU_LED_EN
  ,
  output logic [2:0]   led_fn,
  output logic         led_busy
`endif
);

  alu_state_e state, state_nxt;
  logic [3:0] cnt;
  logic [7:0] b_q, c_q;
  logic [2:0] fn_q;
  logic       dest_q;
  alu_flags_t flags_q;
  logic [7:0] core_result;
  alu_flags_t core_flags;
  logic       settle_last;

  assign settle_last = (cnt == 4'(SETTLE_CYCLES - 1));

  alu_core u_core (
    .b        (b_q),
    .c        (c_q),
    .fn       (fn_q),
    .carry_in (flags_q.c),
    .result   (core_result),
    .flags    (core_flags)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: launch from IDLE, count out the settle time, one LOAD cycle, back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (settle_last) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latches, settle counter, and output registers; outputs are loaded on the
  // SETTLE->LOAD edge so that they are valid for the whole LOAD cycle alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      b_q     <= 8'h00;
      c_q     <= 8'h00;
      fn_q    <= 3'd0;
      dest_q  <= 1'b0;
      result  <= '0;
      flags_q <= '0;
      done    <= 1'b0;
      ld_a    <= 1'b0;
      ld_d    <= 1'b0;
    end else begin
      done <= 1'b0;
      ld_a <= 1'b0;
      ld_d <= 1'b0;
      if (state == IDLE && start) begin
        b_q    <= b[7:0];
        c_q    <= c[7:0];
        fn_q   <= fn;
        dest_q <= dest_d;
        cnt    <= 4'd0;
      end else if (state == SETTLE) begin
        cnt <= cnt + 4'd1;
        if (settle_last) begin
          result  <= core_result;
          flags_q <= core_flags;
          done    <= 1'b1;
          ld_a    <= ~dest_q;
          ld_d    <= dest_q;
        end
      end
    end
  end

  assign busy   = (state != IDLE);
  assign flag_s = flags_q.s;
  assign flag_c = flags_q.c;
  assign flag_z = flags_q.z;

`ifdef ALU_LED_EN
  // Front-panel function lamps follow the function code of the latest launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      led_fn <= 3'd0;
    else if (state == IDLE && start) led_fn <= fn;
  end

  assign led_busy = busy;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] b = 8'h00, c = 8'h00;
  logic [2:0] fn = 3'd0;
  logic       dest_d = 1'b0;
  logic       start4 = 1'b0, start1 = 1'b0;

  logic       busy4, done4, ld_a4, ld_d4, fs4, fc4, fz4;
  logic [7:0] result4;
  logic       busy1, done1, ld_a1, ld_d1, fs1, fc1, fz1;
  logic [7:0] result1;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.SETTLE_CYCLES(4), .N(8)) u4 (
    .clk(clk), .rst_n(rst_n), .b(b), .c(c), .fn(fn), .dest_d(dest_d), .start(start4),
    .busy(busy4), .done(done4), .result(result4), .ld_a(ld_a4), .ld_d(ld_d4),
    .flag_s(fs4), .flag_c(fc4), .flag_z(fz4)
  );

  alu_sequencer #(.SETTLE_CYCLES(1), .N(8)) u1 (
    .clk(clk), .rst_n(rst_n), .b(b), .c(c), .fn(fn), .dest_d(dest_d), .start(start1),
    .busy(busy1), .done(done1), .result(result1), .ld_a(ld_a1), .ld_d(ld_d1),
    .flag_s(fs1), .flag_c(fc1), .flag_z(fz1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op on the SETTLE_CYCLES=4 instance; returns with time in the done cycle
  // (or after a 20-cycle bound). lat counts cycles from k+1 to the done cycle.
  task automatic launch4(input logic [2:0] f, input logic [7:0] bv, input logic [7:0] cv,
                         input logic d, output int lat);
    fn = f; b = bv; c = cv; dest_d = d; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    vec++;
    if ({busy4, done4, ld_a4, ld_d4, fs4, fc4, fz4} !== 7'b0 || result4 !== 8'h00) begin
      errs++;
      $display("FAIL reset_state: busy=%b done=%b ld_a=%b ld_d=%b s=%b c=%b z=%b result=%h, want all 0",
               busy4, done4, ld_a4, ld_d4, fs4, fc4, fz4, result4);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    int lat;
    launch4(3'b000, 8'h7F, 8'h81, 1'b0, lat);
    vec++;
    if (lat !== 4) begin errs++; $display("FAIL add_latency: got %0d cycles after k+1, want 4", lat); end
    vec++;
    if ({result4, fs4, fc4, fz4} !== {8'h00, 3'b011}) begin
      errs++; $display("FAIL add_result: result=%h s=%b c=%b z=%b, want 00 s=0 c=1 z=1", result4, fs4, fc4, fz4);
    end
    vec++;
    if ({done4, ld_a4, ld_d4, busy4} !== 4'b1101) begin
      errs++; $display("FAIL add_strobes: done=%b ld_a=%b ld_d=%b busy=%b, want 1 1 0 1", done4, ld_a4, ld_d4, busy4);
    end
    tick();
    vec++;
    if ({busy4, done4, ld_a4} !== 3'b000 || result4 !== 8'h00) begin
      errs++; $display("FAIL add_after: busy=%b done=%b ld_a=%b result=%h, want 0 0 0 00", busy4, done4, ld_a4, result4);
    end
  endtask

  task automatic test_inc_and();
    int lat;
    launch4(3'b001, 8'hFF, 8'h00, 1'b0, lat);
    vec++;
    if ({result4, fc4, fz4} !== {8'h00, 2'b11}) begin
      errs++; $display("FAIL inc_ff: result=%h c=%b z=%b, want 00 c=1 z=1", result4, fc4, fz4);
    end
    tick();
    launch4(3'b010, 8'hF0, 8'h3C, 1'b0, lat);
    vec++;
    if ({result4, fs4, fc4, fz4} !== {8'h30, 3'b010}) begin
      errs++; $display("FAIL and_hold_c: result=%h s=%b c=%b z=%b, want 30 s=0 c=1 z=0", result4, fs4, fc4, fz4);
    end
    tick();
  endtask

  task automatic test_shl();
    int lat;
    launch4(3'b110, 8'h81, 8'h00, 1'b1, lat);
    vec++;
    if ({result4, fs4} !== {8'h03, 1'b0}) begin
      errs++; $display("FAIL shl: result=%h s=%b, want 03 s=0", result4, fs4);
    end
    vec++;
    if ({done4, ld_a4, ld_d4} !== 3'b101) begin
      errs++; $display("FAIL shl_dest: done=%b ld_a=%b ld_d=%b, want 1 0 1", done4, ld_a4, ld_d4);
    end
    tick();
  endtask

  task automatic test_misc();
    logic [2:0] f_t [4] = '{3'b011, 3'b100, 3'b101, 3'b000};
    logic [7:0] b_t [4] = '{8'h0F, 8'hFF, 8'h55, 8'h10};
    logic [7:0] c_t [4] = '{8'hA0, 8'h0F, 8'h00, 8'h20};
    logic [7:0] r_t [4] = '{8'hAF, 8'hF0, 8'hAA, 8'h30};
    // s, c, z ; carry still 1 from INC until the final ADD clears it
    logic [2:0] f_x [4] = '{3'b110, 3'b110, 3'b110, 3'b000};
    int lat;
    for (int i = 0; i < 4; i++) begin
      launch4(f_t[i], b_t[i], c_t[i], 1'b0, lat);
      vec++;
      if ({result4, fs4, fc4, fz4} !== {r_t[i], f_x[i]}) begin
        errs++;
        $display("FAIL misc_op%0d: result=%h scz=%b%b%b, want %h scz=%b", i, result4, fs4, fc4, fz4, r_t[i], f_x[i]);
      end
      tick();
    end
  endtask

  task automatic test_busy_start();
    int   ndone = 0;
    logic [7:0] rseen = 8'hEE;
    fn = 3'b000; b = 8'h10; c = 8'h20; dest_d = 1'b0; start4 = 1'b1;
    tick();              // edge k sampled
    start4 = 1'b0;
    b = 8'h77; c = 8'h01; // changed during cycle k+1
    tick();
    start4 = 1'b1;        // sampled at edge k+2 while busy
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done4) begin ndone++; rseen = result4; end
      tick();
    end
    vec++;
    if (ndone !== 1) begin errs++; $display("FAIL busy_start_count: %0d done pulses, want 1", ndone); end
    vec++;
    if (rseen !== 8'h30) begin errs++; $display("FAIL busy_start_operands: result=%h, want 30", rseen); end
  endtask

  task automatic test_reset_mid();
    fn = 3'b000; b = 8'h7F; c = 8'h81; dest_d = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();               // cycle k+2, in SETTLE
    rst_n = 1'b0;
    #1;
    vec++;
    if ({busy4, done4, ld_a4, ld_d4, fs4, fc4, fz4} !== 7'b0 || result4 !== 8'h00) begin
      errs++;
      $display("FAIL reset_mid: busy=%b done=%b ld_a=%b ld_d=%b scz=%b%b%b result=%h, want all 0",
               busy4, done4, ld_a4, ld_d4, fs4, fc4, fz4, result4);
    end
    tick(); tick();
    rst_n = 1'b1;
    begin
      int pulses = 0;
      int busy_seen = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (done4 || ld_a4 || ld_d4) pulses++;
        if (busy4) busy_seen++;
      end
      vec++;
      if (pulses !== 0 || busy_seen !== 0) begin
        errs++; $display("FAIL reset_mid_after: %0d strobe cycles, %0d busy cycles, want 0 and 0", pulses, busy_seen);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int cnt = 0;
    int at [8];
    // First set carry on the SETTLE_CYCLES=1 instance.
    fn = 3'b000; b = 8'hFF; c = 8'h01; dest_d = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 10) begin tick(); n++; end
    vec++;
    if ({n, result1, fc1, fz1} !== {32'd1, 8'h00, 2'b11}) begin
      errs++; $display("FAIL s1_add: lat=%0d result=%h c=%b z=%b, want 1 00 1 1", n, result1, fc1, fz1);
    end
    tick(); tick();
    fn = 3'b111; b = 8'h5A; start1 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (done1 && cnt < 8) begin at[cnt] = i; cnt++; end
    end
    start1 = 1'b0;
    vec++;
    if (cnt !== 4 || at[0] !== 2 || at[1] !== 5 || at[2] !== 8 || at[3] !== 11) begin
      errs++; $display("FAIL held_start_period: %0d dones, first at %0d/%0d, want 4 at 2,5,8,11", cnt, at[0], at[1]);
    end
    vec++;
    if ({result1, fs1, fc1, fz1} !== {8'h00, 3'b011}) begin
      errs++; $display("FAIL clr: result=%h scz=%b%b%b, want 00 scz=011", result1, fs1, fc1, fz1);
    end
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_inc_and();
    test_shl();
    test_misc();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
